// File: rtl/match_state_ctrl_if.sv
// match_state_ctrl_if -- keyboard/health inputs and game-state outputs of the match controller.
`default_nettype none

interface match_state_ctrl_if #(
  parameter int HEALTH_W = 8,
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS*8-1:0] keycodes;
  logic [HEALTH_W-1:0]   healthL;
  logic [HEALTH_W-1:0]   healthR;
  logic [2:0]            state;
  logic [1:0]            bg_sel;
  logic                  fight_en;
  logic                  round_start;
  logic                  deathL;
  logic                  deathR;
  logic [2:0]            winsL;
  logic [2:0]            winsR;
  logic [1:0]            winner;

  modport master (
    output keycodes, healthL, healthR,
    input  state, bg_sel, fight_en, round_start, deathL, deathR, winsL, winsR, winner
  );

  modport slave (
    input  keycodes, healthL, healthR,
    output state, bg_sel, fight_en, round_start, deathL, deathR, winsL, winsR, winner
  );
endinterface

`default_nettype wire

// File: rtl/match_state_ctrl.sv
// match_state_ctrl -- round/match sequencer for a two-fighter game. Rev 1.0
`default_nettype none

module match_state_ctrl #(
  parameter int         HEALTH_W      = 8,
  parameter int         KO_THRESH     = 192,
  parameter int         ROUNDS_TO_WIN = 2,
  parameter int         NUM_KEYS      = 4,
  parameter logic [7:0] START_KEY     = 8'h28,
  parameter int         COUNTDOWN_CYC = 75_000_000,
  parameter int         ROUNDEND_CYC  = 50_000_000
) (
  input  logic              clk_25MHz,
  input  logic              Reset,
  match_state_ctrl_if.slave bus
);

  localparam int                CNT_MAX = (COUNTDOWN_CYC > ROUNDEND_CYC) ? COUNTDOWN_CYC : ROUNDEND_CYC;
  localparam int                CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0]  CD_LOAD = CNT_W'(COUNTDOWN_CYC - 1);
  localparam logic [CNT_W-1:0]  RE_LOAD = CNT_W'(ROUNDEND_CYC - 1);
  localparam logic [2:0]        WIN_MAX = 3'(ROUNDS_TO_WIN);
  localparam logic [HEALTH_W-1:0] KO_LVL = HEALTH_W'(KO_THRESH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    FIGHT     = 3'd2,
    ROUND_END = 3'd3,
    MATCH_END = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       wins_l_q, wins_l_d, wins_r_q, wins_r_d;
  logic [1:0]       winner_q, winner_d;
  logic             death_l_q, death_l_d, death_r_q, death_r_d;
  logic             round_start_q, round_start_d;
  logic             fight_en_q;
  logic [1:0]       bg_sel_q, bg_sel_d;
  logic             key_q, key_pressed, start_edge;
  logic             ko_l, ko_r;

  always_comb begin
    key_pressed = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (bus.keycodes[i*8 +: 8] == START_KEY) key_pressed = 1'b1;
    end
  end

  assign start_edge = key_pressed & ~key_q;
  assign ko_l       = (bus.healthL >= KO_LVL);
  assign ko_r       = (bus.healthR >= KO_LVL);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wins_l_d      = wins_l_q;
    wins_r_d      = wins_r_q;
    winner_d      = winner_q;
    death_l_d     = death_l_q;
    death_r_d     = death_r_q;
    round_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d       = COUNTDOWN;
          cnt_d         = CD_LOAD;
          round_start_d = 1'b1;
          wins_l_d      = 3'd0;
          wins_r_d      = 3'd0;
          winner_d      = 2'd0;
        end
      end
      COUNTDOWN: begin
        if (cnt_q == '0) state_d = FIGHT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIGHT: begin
        if (ko_l | ko_r) begin
          state_d   = ROUND_END;
          cnt_d     = RE_LOAD;
          death_l_d = ko_l;
          death_r_d = ko_r;
          // A double KO is a draw: nobody scores.
          if (ko_l & ~ko_r & (wins_r_q < WIN_MAX)) wins_r_d = wins_r_q + 3'd1;
          if (ko_r & ~ko_l & (wins_l_q < WIN_MAX)) wins_l_d = wins_l_q + 3'd1;
        end
      end
      ROUND_END: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((wins_l_q == WIN_MAX) || (wins_r_q == WIN_MAX)) begin
          state_d  = MATCH_END;
          winner_d = (wins_l_q == WIN_MAX) ? 2'd1 : 2'd2;
        end else begin
          state_d       = COUNTDOWN;
          cnt_d         = CD_LOAD;
          round_start_d = 1'b1;
        end
      end
      MATCH_END: begin
        if (start_edge) begin
          state_d   = IDLE;
          death_l_d = 1'b0;
          death_r_d = 1'b0;
          wins_l_d  = 3'd0;
          wins_r_d  = 3'd0;
          winner_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:      bg_sel_d = 2'd0;
      MATCH_END: bg_sel_d = 2'd2;
      default:   bg_sel_d = 2'd1;
    endcase
  end

  always_ff @(posedge clk_25MHz or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wins_l_q      <= 3'd0;
      wins_r_q      <= 3'd0;
      winner_q      <= 2'd0;
      death_l_q     <= 1'b0;
      death_r_q     <= 1'b0;
      round_start_q <= 1'b0;
      fight_en_q    <= 1'b0;
      bg_sel_q      <= 2'd0;
      // Held high so a key already down at reset release is not seen as a press.
      key_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wins_l_q      <= wins_l_d;
      wins_r_q      <= wins_r_d;
      winner_q      <= winner_d;
      death_l_q     <= death_l_d;
      death_r_q     <= death_r_d;
      round_start_q <= round_start_d;
      fight_en_q    <= (state_d == FIGHT);
      bg_sel_q      <= bg_sel_d;
      key_q         <= key_pressed;
    end
  end

  assign bus.state       = state_q;
  assign bus.bg_sel      = bg_sel_q;
  assign bus.fight_en    = fight_en_q;
  assign bus.round_start = round_start_q;
  assign bus.deathL      = death_l_q;
  assign bus.deathR      = death_r_q;
  assign bus.winsL       = wins_l_q;
  assign bus.winsR       = wins_r_q;
  assign bus.winner      = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_match_state_ctrl.sv
// tb_match_state_ctrl -- scoreboard bench for match_state_ctrl with short timer parameters.
`default_nettype none

module tb_match_state_ctrl;

  localparam int HW = 8;
  localparam int NK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_state_ctrl_if #(.HEALTH_W(HW), .NUM_KEYS(NK)) bus ();

  match_state_ctrl #(
    .HEALTH_W(HW), .KO_THRESH(192), .ROUNDS_TO_WIN(2), .NUM_KEYS(NK),
    .START_KEY(8'h28), .COUNTDOWN_CYC(4), .ROUNDEND_CYC(3)
  ) dut (
    .clk_25MHz(clk),
    .Reset(rst),
    .bus(bus)
  );

  typedef enum int {S_STATE, S_BG, S_FEN, S_RS, S_DL, S_DR, S_WL, S_WR, S_WIN} sel_t;
  typedef struct {
    string tag;
    sel_t  sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input sel_t s);
    case (s)
      S_STATE: return int'(bus.state);
      S_BG:    return int'(bus.bg_sel);
      S_FEN:   return int'(bus.fight_en);
      S_RS:    return int'(bus.round_start);
      S_DL:    return int'(bus.deathL);
      S_DR:    return int'(bus.deathR);
      S_WL:    return int'(bus.winsL);
      S_WR:    return int'(bus.winsR);
      default: return int'(bus.winner);
    endcase
  endfunction

  task automatic push(input string tag, input sel_t s, input int v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // One clock, then compare everything queued for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, "_state"}, S_STATE, 0); push({tag, "_bg"}, S_BG, 0);
    push({tag, "_fen"}, S_FEN, 0);     push({tag, "_rs"}, S_RS, 0);
    push({tag, "_dl"}, S_DL, 0);       push({tag, "_dr"}, S_DR, 0);
    push({tag, "_wl"}, S_WL, 0);       push({tag, "_wr"}, S_WR, 0);
    push({tag, "_win"}, S_WIN, 0);
  endtask

  task automatic press_start(input string tag);
    bus.keycodes = 32'h0028_0000;
    push({tag, "_state"}, S_STATE, 1);
    push({tag, "_rs"}, S_RS, 1);
    push({tag, "_bg"}, S_BG, 1);
    tick();
    bus.keycodes = '0;
  endtask

  // COUNTDOWN entry has been checked; three more cycles there, then FIGHT.
  task automatic run_countdown(input string tag);
    for (int i = 0; i < 3; i++) begin
      push({tag, "_cd_state"}, S_STATE, 1);
      push({tag, "_cd_rs"}, S_RS, 0);
      push({tag, "_cd_fen"}, S_FEN, 0);
      tick();
    end
    push({tag, "_fight_state"}, S_STATE, 2);
    push({tag, "_fight_en"}, S_FEN, 1);
    tick();
  endtask

  task automatic ko(input string tag, input int hl, input int hr,
                    input int dl, input int dr, input int wl, input int wr);
    bus.healthL = HW'(hl);
    bus.healthR = HW'(hr);
    push({tag, "_state"}, S_STATE, 3); push({tag, "_fen"}, S_FEN, 0);
    push({tag, "_dl"}, S_DL, dl);      push({tag, "_dr"}, S_DR, dr);
    push({tag, "_wl"}, S_WL, wl);      push({tag, "_wr"}, S_WR, wr);
    tick();
    bus.healthL = '0;
    bus.healthR = '0;
    for (int i = 0; i < 2; i++) begin
      push({tag, "_re_state"}, S_STATE, 3);
      tick();
    end
  endtask

  initial begin
    bus.keycodes = 32'h0000_2800;
    bus.healthL  = '0;
    bus.healthR  = '0;
    #1;
    push_reset_vals("reset");
    drain();
    tick();

    // Start key held across reset release must not start a game.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("held_key_idle", S_STATE, 0);
      tick();
    end
    bus.keycodes = '0;
    push("key_release_idle", S_STATE, 0);
    tick();

    press_start("start1");
    run_countdown("r1");
    bus.keycodes = 32'h0000_0028;
    push("fight_ignores_key", S_STATE, 2);
    tick();
    bus.keycodes = '0;

    ko("r1_left_wins", 10, 192, 0, 1, 1, 0);
    push("r2_restart_state", S_STATE, 1); push("r2_restart_rs", S_RS, 1);
    tick();
    run_countdown("r2");

    ko("r2_draw", 200, 200, 1, 1, 1, 0);
    push("r3_restart_state", S_STATE, 1); push("r3_restart_rs", S_RS, 1);
    tick();
    run_countdown("r3");

    bus.healthL = 8'd191;
    bus.healthR = 8'd191;
    push("below_thresh_state", S_STATE, 2);
    tick();
    ko("r3_left_wins", 0, 192, 0, 1, 2, 0);
    push("match_end_state", S_STATE, 4); push("match_end_bg", S_BG, 2);
    push("match_end_winner", S_WIN, 1);  push("match_end_wl", S_WL, 2);
    push("match_end_rs", S_RS, 0);
    tick();
    push("match_end_hold", S_STATE, 4);
    tick();

    bus.keycodes = 32'h2800_0000;
    push("back_idle_state", S_STATE, 0); push("back_idle_bg", S_BG, 0);
    push("back_idle_wl", S_WL, 0);       push("back_idle_wr", S_WR, 0);
    push("back_idle_dr", S_DR, 0);       push("back_idle_win", S_WIN, 0);
    tick();
    bus.keycodes = '0;
    tick();

    // Right fighter takes a round in a fresh match.
    press_start("start2");
    push("m2_wl_cleared", S_WL, 0);
    run_countdown("m2");
    ko("m2_right_wins", 250, 0, 1, 0, 0, 1);
    push("m2_restart_state", S_STATE, 1);
    tick();

    // Asynchronous reset in the middle of COUNTDOWN.
    tick();
    #2 rst = 1'b1;
    #1;
    push_reset_vals("async_reset");
    drain();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push("post_reset_state", S_STATE, 0);
      push("post_reset_rs", S_RS, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/match_state_ctrl.md
MATCH_STATE_CTRL -- requirements
Module: match_state_ctrl

Interface
REQ-001 SHALL accept parameter: HEALTH_W, 8, width of damage/health inputs.
REQ-002 SHALL accept parameter: KO_THRESH, 192, damage value at or above which a fighter is KO.
REQ-003 SHALL accept parameter: ROUNDS_TO_WIN, 2, round wins needed to end match (1..7).
REQ-004 SHALL accept parameter: NUM_KEYS, 4, number of 8-bit keycode slots scanned.
REQ-005 SHALL accept parameter: START_KEY, 8'h28, keycode that starts/advances the game.
REQ-006 SHALL accept parameter: COUNTDOWN_CYC, 75_000_000, COUNTDOWN duration in clocks (>=2).
REQ-007 SHALL accept parameter: ROUNDEND_CYC, 50_000_000, ROUND_END duration in clocks (>=2).
REQ-008 SHALL have port: clk_25MHz  in  1  sole clock, all state on rising edge.
REQ-009 SHALL have port: Reset  in  1  asynchronous, active-high reset.
REQ-010 SHALL have port: keycodes  in  NUM_KEYS*8  packed keycode slots, slot 0 in bits [7:0].
REQ-011 SHALL have port: healthL, healthR  in  HEALTH_W each  accumulated damage per fighter.
REQ-012 SHALL have port: state  out  3  0=IDLE,1=COUNTDOWN,2=FIGHT,3=ROUND_END,4=MATCH_END.
REQ-013 SHALL have port: bg_sel  out  2  0=welcome, 1=arena, 2=ending, 3 unused.
REQ-014 SHALL have port: fight_en  out  1  player controls enabled.
REQ-015 SHALL have port: round_start  out  1  one-cycle pulse; downstream clears health.
REQ-016 SHALL have port: deathL, deathR  out  1 each  KO flags of last completed round.
REQ-017 SHALL have port: winsL, winsR  out  3 each  round wins in current match.
REQ-018 SHALL have port: winner  out  2  0=none, 1=left, 2=right; valid in MATCH_END.

Function
REQ-019 SHALL compute key_pressed = any slot == START_KEY, register it as key_q, and define start_edge = key_pressed & ~key_q.
REQ-020 SHALL define koL = (healthL >= KO_THRESH), koR = (healthR >= KO_THRESH), unsigned compare.
REQ-021 SHALL, in IDLE, move to COUNTDOWN on start_edge, clearing winsL/winsR/winner in the same edge.
REQ-022 SHALL pulse round_start for exactly the first cycle of every COUNTDOWN entry.
REQ-023 SHALL load a down-counter with COUNTDOWN_CYC-1 on COUNTDOWN entry and move to FIGHT the cycle after it reaches 0 (COUNTDOWN lasts exactly COUNTDOWN_CYC cycles).
REQ-024 SHALL, in FIGHT, assert fight_en and ignore start_edge; on koL|koR latch deathL<=koL, deathR<=koR and move to ROUND_END.
REQ-025 SHALL, on that FIGHT exit edge, increment winsR if koL&~koR, winsL if koR&~koL, neither on simultaneous KO (draw).
REQ-026 SHALL hold wins at ROUNDS_TO_WIN maximum (saturate, never wrap).
REQ-027 SHALL stay in ROUND_END exactly ROUNDEND_CYC cycles, then go MATCH_END if either wins == ROUNDS_TO_WIN, else COUNTDOWN.
REQ-028 SHALL, on entering MATCH_END, set winner to 1 if winsL==ROUNDS_TO_WIN else 2.
REQ-029 SHALL, in MATCH_END, move to IDLE on start_edge; deathL/deathR clear on that edge.
REQ-030 SHALL drive bg_sel 0 in IDLE, 1 in COUNTDOWN/FIGHT/ROUND_END, 2 in MATCH_END.
REQ-031 SHALL register all outputs; fight_en, bg_sel, state change on the same edge as the state register.
REQ-032 SHALL force any illegal state encoding to IDLE on the next edge.

Reset
REQ-033 SHALL, while Reset=1, force state=IDLE, bg_sel=0, fight_en=0, round_start=0, deathL=deathR=0, winsL=winsR=0, winner=0, counter=0.
REQ-034 SHALL reset key_q to 1 so a key held through reset release does not start a game.
REQ-035 SHALL abandon any operation on Reset mid-round with no further round_start or win update.

Verification (COUNTDOWN_CYC=4, ROUNDEND_CYC=3, ROUNDS_TO_WIN=2)
REQ-036 SHALL verify: keycodes slot2=8'h28 one cycle from IDLE -> state=1, round_start high 1 cycle, state=2 exactly 4 cycles later, fight_en=1.
REQ-037 SHALL verify: in FIGHT healthR=192, healthL=10 -> state=3, deathR=1, winsL=1; after 3 cycles state=1 with round_start pulse.
REQ-038 SHALL verify: in FIGHT healthL=healthR=200 -> deathL=deathR=1, wins unchanged, next round starts.
REQ-039 SHALL verify: two left round wins -> state=4, bg_sel=2, winner=1; start_edge -> state=0, wins=0.
REQ-040 SHALL verify: START_KEY held continuously through Reset release -> stays IDLE; release and repress -> COUNTDOWN.
REQ-041 SHALL verify: Reset asserted mid-COUNTDOWN -> all outputs at reset values asynchronously, before next clock edge.
